// File: rtl/lfsr_pkg.sv
// Shared types and default feedback polynomials for the LFSR burst generator.
// Default taps are maximal-length masks for the common widths.
package lfsr_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HOLD,
        DONE
    } fsm_state_e;

    typedef enum logic {
        MODE_FIB,
        MODE_GAL
    } lfsr_mode_e;

    localparam logic [7:0]  TAPS_8  = 8'hB8;
    localparam logic [15:0] TAPS_16 = 16'hB400;
    localparam logic [31:0] TAPS_32 = 32'hA3000000;

    // Other widths fall back to a non-zero mask using the top and bottom
    // bits; designs at those widths should supply their own TAPS.
    function automatic logic [63:0] default_taps(input int width);
        case (width)
            8:       return 64'(TAPS_8);
            16:      return 64'(TAPS_16);
            32:      return 64'(TAPS_32);
            default: return (64'(1) << (width - 1)) | 64'(1);
        endcase
    endfunction

endpackage

// File: rtl/lfsr_step.sv
// Combinational next-state function of the LFSR, Fibonacci or Galois form,
// with all-zero state replaced by ZERO_SUB.
module lfsr_step
    import lfsr_pkg::*;
#(
    parameter int                N_BITS   = 8,
    parameter logic [N_BITS-1:0] TAPS     = N_BITS'(default_taps(N_BITS)),
    parameter int                ZERO_SUB = 1
) (
    input  logic [N_BITS-1:0] state,
    input  lfsr_mode_e        mode,
    output logic [N_BITS-1:0] next_state
);

    localparam logic [N_BITS-1:0] ZERO_VAL = N_BITS'(ZERO_SUB);

    logic              fb;
    logic [N_BITS-1:0] fib;
    logic [N_BITS-1:0] gal;
    logic [N_BITS-1:0] raw;

    always_comb begin
        fb  = ^(state & TAPS);
        fib = {state[N_BITS-2:0], fb};
        gal = (state >> 1) ^ (state[0] ? TAPS : '0);
        raw = (mode == MODE_GAL) ? gal : fib;
        // Zero is a lock-up state; only a faulty polynomial can reach it.
        next_state = (raw == '0) ? ZERO_VAL : raw;
    end

endmodule

// File: rtl/lfsr_burst_gen.sv
// Pseudo-random address generator: seeded LFSR stepped under a valid/ready
// handshake, emitting bounded bursts (or free-running) with a done pulse.
module lfsr_burst_gen
    import lfsr_pkg::*;
#(
    parameter int                N_BITS   = 8,
    parameter logic [N_BITS-1:0] TAPS     = N_BITS'(default_taps(N_BITS)),
    parameter int                CNT_W    = 16,
    parameter int                ZERO_SUB = 1
) (
    input  logic              clk,
    input  logic              rst_ni,
    input  logic              start_bit,
    input  logic              en,
    input  logic              mode_i,
    input  logic [N_BITS-1:0] seed_address,
    input  logic [CNT_W-1:0]  burst_len_i,
    input  logic              out_ready_i,
    output logic [N_BITS-1:0] lfsr_output,
    output logic              out_valid_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [CNT_W-1:0]  step_cnt_o
);

    localparam logic [N_BITS-1:0] ZERO_VAL = N_BITS'(ZERO_SUB);

    fsm_state_e        fsm_q, fsm_d;
    lfsr_mode_e        mode_q, mode_d;
    logic [N_BITS-1:0] state_q, state_d;
    logic [CNT_W-1:0]  len_q, len_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [N_BITS-1:0] step_next;
    logic [CNT_W-1:0]  cnt_inc;

    lfsr_step #(
        .N_BITS   (N_BITS),
        .TAPS     (TAPS),
        .ZERO_SUB (ZERO_SUB)
    ) u_step (
        .state      (state_q),
        .mode       (mode_q),
        .next_state (step_next)
    );

    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

    // NOTE: every signal driven here gets its hold value first, so no path
    // through the case leaves one unassigned and no latch is inferred.
    always_comb begin
        fsm_d   = fsm_q;
        mode_d  = mode_q;
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        if (start_bit) begin
            state_d = (seed_address == '0) ? ZERO_VAL : seed_address;
            mode_d  = lfsr_mode_e'(mode_i);
            len_d   = burst_len_i;
            cnt_d   = '0;
            fsm_d   = RUN;
        end else begin
            case (fsm_q)
                RUN: begin
                    if (en) begin
                        state_d = step_next;
                        cnt_d   = cnt_inc;
                        fsm_d   = HOLD;
                    end
                end
                HOLD: begin
                    if (out_ready_i) begin
                        fsm_d = (len_q != '0 && cnt_q == len_q) ? DONE : RUN;
                    end
                end
                DONE:    fsm_d = IDLE;
                default: fsm_d = fsm_q;
            endcase
        end
    end

    // NOTE: registers use non-blocking assignments so every flop samples the
    // values from before this edge, independent of statement order.
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            fsm_q   <= IDLE;
            mode_q  <= MODE_FIB;
            state_q <= ZERO_VAL;
            len_q   <= '0;
            cnt_q   <= '0;
        end else begin
            fsm_q   <= fsm_d;
            mode_q  <= mode_d;
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
        end
    end

    // A value is pending exactly while the FSM sits in HOLD.
    assign lfsr_output = state_q;
    assign out_valid_o = (fsm_q == HOLD);
    assign busy_o      = (fsm_q == RUN) || (fsm_q == HOLD);
    assign done_o      = (fsm_q == DONE);
    assign step_cnt_o  = cnt_q;

endmodule

// File: doc/lfsr_burst_gen.md
Name: lfsr_burst_gen

Overview:
- Parametrised pseudo-random address generator for the fault-generator model.
- Successor to the fixed 8-bit LFSR. Adds:
  - width and polynomial generics;
  - runtime Fibonacci/Galois mode select;
  - bounded burst length with a done pulse;
  - valid/ready output handshake;
  - all-zero lock-up protection.
- Sits between the fault controller (start/seed/length) and the fault-injection address consumer.

Parameters:
- N_BITS, 8, LFSR state and output width (min 3).
- TAPS, 8'hB8, feedback polynomial mask, N_BITS wide; bit i set = state bit i participates.
- CNT_W, 16, width of burst length and step counter.
- ZERO_SUB, 1, value substituted when a zero seed is loaded or the all-zero state is reached.

Ports:
- clk, in, 1, clock; all state updates on the rising edge.
- rst_ni, in, 1, reset; asynchronous, active-low.
- start_bit, in, 1, load seed, clear counter, arm a burst.
- en, in, 1, step enable while running.
- mode_i, in, 1, 0 = Fibonacci, 1 = Galois; sampled on start_bit.
- seed_address, in, N_BITS, seed value; sampled on start_bit.
- burst_len_i, in, CNT_W, values to emit; 0 = free-running; sampled on start_bit.
- out_ready_i, in, 1, consumer accepts lfsr_output.
- lfsr_output, out, N_BITS, current LFSR state.
- out_valid_o, out, 1, lfsr_output holds a new, unconsumed value.
- busy_o, out, 1, FSM in RUN or HOLD.
- done_o, out, 1, one-cycle pulse when the burst completes.
- step_cnt_o, out, CNT_W, values emitted in the current burst.

Behaviour:
- Reset (async assert, sync-safe deassert):
  - state = ZERO_SUB, FSM = IDLE, mode = 0, count = 0;
  - out_valid_o = 0, busy_o = 0, done_o = 0, step_cnt_o = 0, lfsr_output = ZERO_SUB.
- FSM states: IDLE, RUN, HOLD, DONE.
- start_bit = 1 in any state (highest priority after reset):
  - state = (seed_address == 0) ? ZERO_SUB : seed_address;
  - latch mode_i and burst_len_i; count = 0; out_valid_o = 0; next FSM = RUN;
  - en is ignored in the start cycle.
- Fibonacci step:
  - fb = ^(state & TAPS);
  - next = {state[N_BITS-2:0], fb}.
- Galois step:
  - next = (state >> 1) ^ (state[0] ? TAPS : 0).
- If a computed next state is 0, ZERO_SUB is loaded instead. This is unreachable with a primitive TAPS and exists as a fault guard.
- RUN:
  - en = 1: step the LFSR; out_valid_o = 1 the next cycle; count += 1 saturating at all-ones; next FSM = HOLD.
  - en = 0: hold state, no valid.
  - Latency is one cycle from en to the new value plus valid.
- HOLD (value presented):
  - out_valid_o = 1 and lfsr_output is stable until out_ready_i = 1.
  - Accept cycle (valid && ready): out_valid_o drops next cycle.
    - If burst_len != 0 and count == burst_len: next FSM = DONE.
    - Otherwise: next FSM = RUN.
  - en is ignored while in HOLD; there is no overwrite of an unconsumed value.
- DONE:
  - done_o = 1 for exactly one cycle, then IDLE.
  - lfsr_output retains the last value; step_cnt_o retains the final count.
- IDLE:
  - en is ignored; outputs hold.
- busy_o = 1 in RUN and HOLD.
- burst_len = 0: never enters DONE; count saturates but output continues.
- Reset mid-burst: immediate return to reset values; any pending value is lost and there is no done pulse.
- start_bit during HOLD: the pending value is discarded (valid drops) and the burst restarts.

Decomposition:
- Package lfsr_pkg holds:
  - typedef enum fsm_state_e {IDLE, RUN, HOLD, DONE};
  - typedef enum lfsr_mode_e {MODE_FIB, MODE_GAL};
  - default TAPS constants per width (8: 'hB8, 16: 'hB400, 32: 'hA3000000).
- Sub-module lfsr_step: purely combinational next-state function (state, mode, TAPS → next, including zero substitution). It is reused by the checker model in the bench.

Test Plan:
- Fibonacci basic:
  - Stimulus: reset, start with seed 0xAA, mode 0, len 2, en = 1, ready = 1.
  - Response: outputs 0x55 then 0xAB; done_o pulses once; step_cnt_o = 2; busy_o falls.
- Galois basic:
  - Stimulus: seed 0xAA, mode 1, len 2.
  - Response: outputs 0x55 then 0x92.
- Zero seed:
  - Stimulus: seed 0x00, mode 0.
  - Response: state loads 0x01; first output 0x02; the state is never 0.
- Backpressure:
  - Stimulus: out_ready_i low for 5 cycles after the first valid.
  - Response: lfsr_output and out_valid_o stable for all 5 cycles; no step or count change despite en = 1; resumes after accept.
- Free-running period:
  - Stimulus: len 0, seed 0x01, both modes.
  - Response: value 0x01 recurs after exactly 255 steps; no done_o.
- Reset and restart:
  - Stimulus: rst_ni pulsed low mid-burst (count 3).
  - Response: outputs return to reset values; no done_o.
  - Stimulus: start_bit during HOLD with seed 0xAB.
  - Response: valid drops; next output is the step from 0xAB (Fibonacci 0x57).
